axi_slave_read_fsm: RTL and testbench

AXI read-channel responder: accepts a read address (AR) handshake, walks the burst address sequence, issues one synchronous-memory read per beat and returns each beat on the R channel with correct RLAST/RRESP under RREADY backpressure. It is the read-direction counterpart of the AXI write-path FSM and sits between the AXI slave port and the same single-port synchronous memory.

---
 rtl/axi_rd_pkg.sv | 10 +
 rtl/axi_rd_addr_gen.sv | 26 ++
 rtl/axi_slave_read_fsm.sv | 84 ++++++++
 tb/tb_axi_slave_read_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// axi_rd_pkg: burst/response encodings and read FSM states for the AXI read responder
package axi_rd_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] BURST_RSVD = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_e;
endpackage

// File: rtl/axi_rd_addr_gen.sv
// axi_rd_addr_gen: next beat address (addr,len,burst -> next_addr) for FIXED/INCR, plus WRAP when AXI_RD_WRAP_EN is defined
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  localparam int STEP = DATA_W / 8;
  logic [ADDR_W-1:0] incr;
  assign incr = addr + ADDR_W'(STEP);
`ifdef AXI_RD_WRAP_EN
  logic [ADDR_W-1:0] mask;
  assign mask = (ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(STEP) - ADDR_W'(1);
  always_comb next_addr = burst == BURST_FIXED ? addr :
                          burst == BURST_WRAP ? (addr & ~mask) | (incr & mask) : incr;
`else
  logic unused_len;
  assign unused_len = ^len;
  always_comb next_addr = burst == BURST_FIXED ? addr : incr;
`endif
endmodule

// File: rtl/axi_slave_read_fsm.sv
// axi_slave_read_fsm: AXI AR/R responder driving a sync memory (o_ren/o_raddr -> i_rdata next cycle); WRAP bursts need AXI_RD_WRAP_EN
module axi_slave_read_fsm
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata
);
  state_e state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] data;
  logic [7:0] len, beat;
  logic [1:0] burst;
  logic err, bad, last;
  axi_rd_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gen (
    .addr(addr),
    .len(len),
    .burst(burst),
    .next_addr(addr_nx)
  );
`ifdef AXI_RD_WRAP_EN
  assign bad = s_arburst == BURST_RSVD ||
               (s_arburst == BURST_WRAP && !(s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
  assign bad = s_arburst[1];
`endif
  assign last = beat == len;
  assign s_arready = state == IDLE && !rst;
  assign s_rvalid = state == SEND;
  assign s_rlast = s_rvalid && last;
  assign s_rresp = s_rvalid && err ? RESP_SLVERR : RESP_OKAY;
  assign s_rdata = data;
  assign o_ren = state == FETCH && !err;
  assign o_raddr = state == FETCH ? addr : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = s_arvalid ? FETCH : IDLE;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = !s_rready ? SEND : last ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      burst <= '0;
      beat <= '0;
      err <= 1'b0;
      data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && s_arvalid) begin
        addr <= s_araddr;
        len <= s_arlen;
        burst <= s_arburst;
        beat <= '0;
        err <= bad;
      end
      if (state == LOAD) data <= err ? '0 : i_rdata;
      if (state == SEND && s_rready && !last) begin
        addr <= addr_nx;
        beat <= beat + 8'd1;
      end
    end
endmodule

// File: tb/tb_axi_slave_read_fsm.sv
// tb_axi_slave_read_fsm: randomized scoreboard bench for axi_slave_read_fsm against a burst-level reference model
module tb_axi_slave_read_fsm;
`ifdef AXI_RD_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr = '0;
  logic [7:0] s_arlen = '0;
  logic [1:0] s_arburst = '0;
  logic s_rvalid, s_rready = 1'b0, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp;
  logic o_ren;
  logic [31:0] o_raddr;
  logic [31:0] i_rdata = '0;
  int vectors = 0, miscompares = 0;
  int n = 0, due = -1, ar_due = -1, rcnt = 0, mode = 0;
  logic hold = 1'b0, pend = 1'b0;
  beat_t eq[$];
  logic [31:0] aq[$];

  axi_slave_read_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_araddr(s_araddr),
    .s_arlen(s_arlen),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .s_rdata(s_rdata),
    .s_rresp(s_rresp),
    .s_rlast(s_rlast),
    .o_ren(o_ren),
    .o_raddr(o_raddr),
    .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  always @(posedge clk) if (o_ren) i_rdata <= mem_f(o_raddr);

  always @(posedge clk) begin
    #1;
    s_rready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : !hold;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void expect_burst(logic [31:0] a, logic [7:0] l, logic [1:0] b);
    logic err;
    logic [31:0] total, base, cur;
    err = b == 2'b11 || (b == 2'b10 && (!WRAP_EN || !(l == 1 || l == 3 || l == 7 || l == 15)));
    total = (32'(l) + 1) * 4;
    base = a - (a % total);
    for (int i = 0; i <= int'(l); i++) begin
      cur = b == 2'b00 ? a : b == 2'b01 ? a + 32'(4 * i) : base + ((a - base + 32'(4 * i)) % total);
      if (!err) aq.push_back(cur);
      eq.push_back('{err ? 32'h0 : mem_f(cur), err ? 2'b10 : 2'b00, i == int'(l)});
    end
  endfunction

  always @(negedge clk) begin
    n++;
    if (rst) begin
      pend = 1'b0;
      due = -1;
      ar_due = -1;
    end else begin
      if (s_arvalid && s_arready) begin
        expect_burst(s_araddr, s_arlen, s_arburst);
        due = n + 3;
      end
      if (o_ren) begin
        if (aq.size() == 0) chk("unexpected_ren", {1'b1, o_raddr}, 0);
        else chk("raddr", o_raddr, aq.pop_front());
      end
      if (s_rvalid) begin
        if (eq.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin
          chk("rbeat{data,resp,last,arready}", {s_rdata, s_rresp, s_rlast, s_arready},
              {eq[0].d, eq[0].r, eq[0].l, 1'b0});
          if (!pend) chk("rvalid_latency", n, due);
          if (s_rready) begin
            void'(eq.pop_front());
            rcnt++;
            if (s_rlast) ar_due = n + 1;
            else due = n + 3;
          end
        end
      end
      if (n == ar_due) chk("arready_after_last", s_arready, 1);
      pend = s_rvalid && !s_rready;
    end
  end

  task automatic issue(logic [31:0] a, logic [7:0] l, logic [1:0] b);
    int t = 0;
    @(posedge clk);
    #1;
    s_arvalid = 1'b1;
    s_araddr = a;
    s_arlen = l;
    s_arburst = b;
    do begin
      @(negedge clk);
      t++;
    end while (!s_arready && t < 100);
    chk("ar_accept", s_arready, 1);
    @(posedge clk);
    #1 s_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(s_arready && eq.size() == 0) && t < 4000);
    chk("idle_reached", t < 4000, 1);
  endtask

  task automatic wait_rcnt(int target);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (rcnt < target && t < 200);
    chk("rcnt_reached", rcnt >= target, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    logic [31:0] a;
    logic [7:0] l;
    logic [1:0] b;
    logic [7:0] wl[4] = '{8'd1, 8'd3, 8'd7, 8'd15};
    #3;
    chk("reset_outputs", {s_arready, s_rvalid, s_rlast, o_ren, s_rresp, s_rdata, o_raddr}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arready_after_reset", s_arready, 1);
    issue(32'h100, 8'd3, 2'b01);
    wait_idle();
    issue(32'h40, 8'd2, 2'b00);
    wait_idle();
    issue(32'h18, 8'd3, 2'b10);
    wait_idle();
    issue(32'h80, 8'd0, 2'b11);
    wait_idle();
    mode = 2;
    hold = 1'b0;
    base = rcnt;
    issue(32'h500, 8'd3, 2'b01);
    wait_rcnt(base + 2);
    hold = 1'b1;
    t = 0;
    for (int k = 0; k < 5 && t < 50; t++) begin
      @(negedge clk);
      if (s_rvalid) k++;
    end
    hold = 1'b0;
    wait_idle();
    mode = 0;
    base = rcnt;
    issue(32'h200, 8'd3, 2'b01);
    wait_rcnt(base + 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_ren && t < 20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_burst_reset{rvalid,arready,ren}", {s_rvalid, s_arready, o_ren}, 0);
    eq.delete();
    aq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("arready_after_mid_reset", s_arready, 1);
    issue(32'h300, 8'd1, 2'b01);
    wait_idle();
    issue(32'h600, 8'd0, 2'b01);
    wait_idle();
    issue(32'hFFFF_FFF8, 8'd3, 2'b01);
    wait_idle();
    issue(32'h1000, 8'd255, 2'b01);
    wait_idle();
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      b = 2'($urandom_range(0, 3));
      l = $urandom_range(0, 1) != 0 ? wl[$urandom_range(0, 3)] : 8'($urandom_range(0, 15));
      a = 32'($urandom) & 32'hFFFF_FFFC;
      issue(a, l, b);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("queues_drained", {32'(eq.size()), 32'(aq.size())}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
